ccff_bitstream_loader: RTL and testbench
========================================

# ccff_bitstream_loader

Configuration-chain loader that drives the `ccff_head` input of a logic-tile configuration chain, such as the ble6 chain of 64 LUT bits followed by 3 output-mux bits. It accepts the bitstream as bytes over a valid/ready stream and serialises it one bit per `prog_clk` cycle. It also produces a shift-enable for the chain's clock gate. An optional verify pass recirculates the chain through `ccff_tail` and checks a CRC-16 of the returned bits against the CRC of the loaded bits.

## Interface
Parameters:
- `CHAIN_LEN`, default 67: number of configuration bits in the chain (64 LUT + 3 mux).
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: width of the bit counter.

Ports:
- `prog_clk` in 1: the single clock for the whole block.
- `pReset` in 1: synchronous reset, active-high.
- `start` in 1: single-cycle request to begin a load; ignored while `busy`=1.
- `verify_en` in 1: enables the verify pass; sampled only on the cycle `start` is accepted.
- `s_data` in 8: bitstream byte; bit 7 is shifted first.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: block accepts `s_data` this cycle.
- `ccff_head` out 1: serial data into the chain.
- `ccff_tail` in 1: serial data out of the chain.
- `chain_shift_en` out 1: enable for the chain's `prog_clk` gate.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: single-cycle completion pulse.
- `crc_err` out 1: sticky verify mismatch; cleared on the next accepted `start`.
- `crc_out` out 16: CRC of the loaded bits.

## Operation
- States are IDLE, LOAD, VERIFY and DONE.
- **IDLE → LOAD:** taken on `start`=1.
  - `verify_en` is latched.
  - Both CRCs are initialised to 0xFFFF.
  - The bit counter is cleared and `crc_err` is cleared.
- **LOAD, byte handling:**
  - An 8-bit shift buffer and a 3-bit index serialise each byte.
  - A byte is accepted on `s_valid & s_ready`.
  - `s_ready`=1 when the buffer is empty, or when its last valid bit is shifting this cycle, and fewer than `CHAIN_LEN` bits have been issued counting the buffer contents.
- **LOAD, per issued bit:**
  - `ccff_head` = the buffer bit.
  - `chain_shift_en`=1.
  - The load CRC is updated.
  - The bit counter increments.
- **LOAD, last byte:** only the top (`CHAIN_LEN` mod 8) bits are issued (all 8 if the remainder is 0). The remaining low bits are discarded and are excluded from the CRC.
- **LOAD, stall:** if no buffered bit is available, `chain_shift_en`=0 and `ccff_head` holds its value. No bit is lost or duplicated.
- **LOAD → next state:** after bit `CHAIN_LEN`, the block goes to VERIFY if `verify_en` is latched, otherwise to DONE.
- **VERIFY:**
  - Runs for exactly `CHAIN_LEN` cycles with `chain_shift_en`=1 and `ccff_head` = `ccff_tail`, sampled in the same cycle (pre-shift value). The chain contents are therefore restored.
  - The verify CRC is updated with each `ccff_tail` bit; bits emerge in load order.
  - Then the block goes to DONE.
- **DONE:**
  - `done`=1 for exactly one cycle, then the block returns to IDLE.
  - If verify ran, `crc_err` = (verify CRC ≠ load CRC).
- **CRC:** CRC-16-CCITT, polynomial 0x1021, initial value 0xFFFF, MSB-first, no final XOR, one bit per cycle. `crc_out` holds its value after DONE until the next `start`.
- **`pReset` mid-operation:**
  - At the next edge, the state becomes IDLE and all counters and the buffer clear.
  - `chain_shift_en`=0 from the next cycle on.
  - The partial chain contents are undefined; a new `start` fully reloads the chain.
- **Simultaneous `start` and `pReset`:** reset wins.

## Timing
- Reset values: `s_ready`=0, `ccff_head`=0, `chain_shift_en`=0, `busy`=0, `done`=0, `crc_err`=0, `crc_out`=0xFFFF.
- `ccff_head` and `chain_shift_en` are registered and aligned. The chain captures `ccff_head` at the end of every cycle in which `chain_shift_en`=1.
- `start` in cycle T gives LOAD with `s_ready`=1 in T+1. A byte accepted in T+1 gives its first bit on `ccff_head` with `chain_shift_en`=1 in T+2.
- With `s_valid` held high, bits issue continuously with no bubbles.
  - Load alone: `done` in T+2+`CHAIN_LEN`.
  - With verify: `done` in T+2+2·`CHAIN_LEN`.
- `s_ready`=0 in IDLE, VERIFY and DONE. It is also 0 once all `CHAIN_LEN` bits are buffered or issued, so extra bytes are never accepted.
- `busy`=1 from T+1 through the DONE cycle inclusive.

## Test plan
- **Reset:** hold `pReset` for 3 cycles with random inputs → all outputs at their reset values; `s_ready`=0.
- **Continuous load:** `CHAIN_LEN`=67, `verify_en`=0, 9 bytes 0xA5, 0x3C, …, 0xE0 with `s_valid` held high → exactly 67 enabled cycles, no gaps. A 67-bit model shift register matches the expected bits; only the top 3 bits of byte 9 are used; `done` at T+69; the 10th byte is not accepted.
- **Stalls:** same data with `s_valid` toggling 1,0,0,1 → `chain_shift_en` drops during gaps; final chain contents are identical to the continuous case; `crc_out` is identical.
- **Verify pass:** `verify_en`=1 with a healthy model chain looped to `ccff_tail` → 134 enabled cycles; `done` at T+136; `crc_err`=0; chain contents unchanged after verify.
- **Fault detection:** `verify_en`=1 with `ccff_tail` stuck at 0 and a bitstream containing 1s → `crc_err`=1 after `done`. The next `start` clears `crc_err` in T+1.
- **Reset mid-load:** assert `pReset` at issued bit 30 → next cycle `chain_shift_en`=0, `busy`=0, no `done`. A following `start` with a full reload gives correct chain contents and `done` at the expected cycle.

Source files
------------

// File: rtl/ccff_bitstream_loader_if.sv
// Byte stream carrying the configuration bitstream into the chain loader.
//   s_data  : bitstream byte, bit 7 is shifted into the chain first
//   s_valid : s_data holds a valid byte
//   s_ready : loader accepts s_data this cycle
// master drives the bytes; slave is the loader.
interface ccff_bitstream_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader. Serialises a byte stream onto ccff_head, one bit per prog_clk,
// with a matching shift enable for the chain's clock gate. An optional verify pass recirculates
// the chain through ccff_tail and compares a CRC-16-CCITT of the returned bits with the CRC of
// the loaded bits.
//   prog_clk, pReset : clock, synchronous active-high reset
//   start, verify_en : load request (IDLE only); verify_en is latched with start
//   s_if             : byte stream (slave side)
//   ccff_head/tail   : serial data into / out of the chain
//   chain_shift_en   : chain clock-gate enable
//   busy, done       : not-idle flag, one-cycle completion pulse
//   crc_err, crc_out : sticky verify mismatch, CRC of the loaded bits
module ccff_bitstream_loader #(
  parameter int unsigned CHAIN_LEN = 67,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                          prog_clk,
  input  logic                          pReset,
  input  logic                          start,
  input  logic                          verify_en,
  ccff_bitstream_loader_if.slave        s_if,
  output logic                          ccff_head,
  input  logic                          ccff_tail,
  output logic                          chain_shift_en,
  output logic                          busy,
  output logic                          done,
  output logic                          crc_err,
  output logic [15:0]                   crc_out
);

  typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;

  localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] VerifyEnd = CNT_W'(CHAIN_LEN - 1);

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  state_e           state_q, state_d;
  logic             verify_q, verify_d;
  logic [7:0]       buf_q, buf_d;       // left-aligned, MSB is the next bit out
  logic [3:0]       buf_cnt_q, buf_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             head_q, head_d;
  logic             shift_en_q, shift_en_d;
  logic [15:0]      crc_load_q, crc_load_d;
  logic [15:0]      crc_ver_q, crc_ver_d;
  logic             crc_err_q, crc_err_d;

  logic [CNT_W:0]   pending;   // bits issued plus bits still buffered
  logic [CNT_W:0]   remaining;
  logic [3:0]       new_cnt;   // valid bits in the byte being accepted
  logic             s_ready;
  logic             accept;
  logic             issue;
  logic             issue_bit;

  assign pending   = {1'b0, bit_cnt_q} + (CNT_W + 1)'(buf_cnt_q);
  assign remaining = (CNT_W + 1)'(CHAIN_LEN) - pending;
  assign new_cnt   = (remaining >= (CNT_W + 1)'(8)) ? 4'd8 : 4'(remaining);
  // A byte can land when the buffer is empty or its last bit leaves this cycle.
  assign s_ready   = (state_q == StLoad) && (buf_cnt_q <= 4'd1) &&
                     (pending < (CNT_W + 1)'(CHAIN_LEN));
  assign accept    = s_if.s_valid & s_ready;

  always_comb begin
    state_d    = state_q;
    verify_d   = verify_q;
    buf_d      = buf_q;
    buf_cnt_d  = buf_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    head_d     = head_q;
    shift_en_d = 1'b0;
    crc_load_d = crc_load_q;
    crc_ver_d  = crc_ver_q;
    crc_err_d  = crc_err_q;
    issue      = 1'b0;
    issue_bit  = head_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          verify_d   = verify_en;
          buf_d      = '0;
          buf_cnt_d  = '0;
          bit_cnt_d  = '0;
          crc_load_d = 16'hFFFF;
          crc_ver_d  = 16'hFFFF;
          crc_err_d  = 1'b0;
        end
      end
      StLoad: begin
        if (bit_cnt_q == LastCnt) begin
          // The last bit is on ccff_head this cycle; leave once it has shifted.
          bit_cnt_d = '0;
          if (verify_q) begin
            state_d    = StVerify;
            shift_en_d = 1'b1;
          end else begin
            state_d = StDone;
          end
        end else begin
          if (buf_cnt_q != 4'd0) begin
            issue     = 1'b1;
            issue_bit = buf_q[7];
            buf_d     = {buf_q[6:0], 1'b0};
            buf_cnt_d = buf_cnt_q - 4'd1;
            if (accept) begin
              buf_d     = s_if.s_data;
              buf_cnt_d = new_cnt;
            end
          end else if (accept) begin
            // Empty buffer: the accepted byte's MSB goes straight out.
            issue     = 1'b1;
            issue_bit = s_if.s_data[7];
            buf_d     = {s_if.s_data[6:0], 1'b0};
            buf_cnt_d = new_cnt - 4'd1;
          end
          if (issue) begin
            head_d     = issue_bit;
            shift_en_d = 1'b1;
            crc_load_d = crc_step(crc_load_q, issue_bit);
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      StVerify: begin
        crc_ver_d = crc_step(crc_ver_q, ccff_tail);
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == VerifyEnd) begin
          state_d = StDone;
        end else begin
          shift_en_d = 1'b1;
        end
      end
      StDone: begin
        crc_err_d = verify_q & (crc_ver_q != crc_load_q);
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q    <= StIdle;
      verify_q   <= 1'b0;
      buf_q      <= '0;
      buf_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      crc_load_q <= 16'hFFFF;
      crc_ver_q  <= 16'hFFFF;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      verify_q   <= verify_d;
      buf_q      <= buf_d;
      buf_cnt_q  <= buf_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
      crc_load_q <= crc_load_d;
      crc_ver_q  <= crc_ver_d;
      crc_err_q  <= crc_err_d;
    end
  end

  assign s_if.s_ready   = s_ready;
  // During verify the chain recirculates: tail feeds head in the same cycle.
  assign ccff_head      = (state_q == StVerify) ? ccff_tail : head_q;
  assign chain_shift_en = shift_en_q;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign crc_err        = crc_err_q;
  assign crc_out        = crc_load_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 67-bit model chain hangs off ccff_head/ccff_tail and
// directed loads are driven through the byte-stream interface.
module tb_ccff_bitstream_loader;
  localparam int unsigned ChainLen = 67;
  // First bit loaded ends up at the tail end (MSB); only the top 3 bits of 0xE0 are used.
  localparam logic [ChainLen-1:0] ExpChain =
    {8'hA5, 8'h3C, 8'h96, 8'h0F, 8'h5A, 8'hC3, 8'h69, 8'hF0, 3'b111};

  logic        prog_clk = 1'b0;
  logic        pReset;
  logic        start;
  logic        verify_en;
  logic        ccff_head;
  logic        ccff_tail;
  logic        chain_shift_en;
  logic        busy;
  logic        done;
  logic        crc_err;
  logic [15:0] crc_out;

  ccff_bitstream_loader_if s_if ();

  ccff_bitstream_loader #(
    .CHAIN_LEN (ChainLen)
  ) dut (
    .prog_clk       (prog_clk),
    .pReset         (pReset),
    .start          (start),
    .verify_en      (verify_en),
    .s_if           (s_if.slave),
    .ccff_head      (ccff_head),
    .ccff_tail      (ccff_tail),
    .chain_shift_en (chain_shift_en),
    .busy           (busy),
    .done           (done),
    .crc_err        (crc_err),
    .crc_out        (crc_out)
  );

  always #5 prog_clk = ~prog_clk;

  logic [ChainLen-1:0] chain_q = '0;
  bit                  tail_stuck = 1'b0;

  always @(posedge prog_clk) begin
    if (chain_shift_en) chain_q <= {chain_q[ChainLen-2:0], ccff_head};
  end
  assign ccff_tail = tail_stuck ? 1'b0 : chain_q[ChainLen-1];

  logic [7:0] stream [10] = '{8'hA5, 8'h3C, 8'h96, 8'h0F, 8'h5A, 8'hC3, 8'h69, 8'hF0,
                              8'hE0, 8'h55};

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [66:0] got, input logic [66:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC-16-CCITT, poly 0x1021, init 0xFFFF, MSB first over the chain bits in load order.
  function automatic logic [15:0] crc_model(input logic [ChainLen-1:0] bits);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = ChainLen - 1; i >= 0; i--) begin
      if (c[15] ^ bits[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  task automatic run_load(input string name, input bit do_verify, input bit stall,
                          input int abort_at, input int exp_done, input bit exp_err);
    int rel;
    int n_en;
    int first_en;
    int last_en;
    int n_done;
    int done_rel;
    int n_acc;
    n_en = 0; first_en = -1; last_en = -1; n_done = 0; done_rel = -1; n_acc = 0;

    @(posedge prog_clk); #1;
    start = 1'b1; verify_en = do_verify; s_if.s_valid = 1'b0;
    @(posedge prog_clk); #1;
    start = 1'b0; verify_en = 1'b0; rel = 1;
    check_eq({name, "_busy_t1"}, busy, 1'b1);
    check_eq({name, "_ready_t1"}, s_if.s_ready, 1'b1);
    check_eq({name, "_crc_err_t1"}, crc_err, 1'b0);

    while (rel < 400) begin
      s_if.s_valid = stall ? ((rel % 4 == 0) || (rel % 4 == 3)) : 1'b1;
      s_if.s_data  = stream[(n_acc > 9) ? 9 : n_acc];
      if (s_if.s_valid && s_if.s_ready) n_acc++;
      if (chain_shift_en) begin
        n_en++;
        if (first_en < 0) first_en = rel;
        last_en = rel;
      end
      if (done) begin
        n_done++;
        done_rel = rel;
        check_eq({name, "_busy_at_done"}, busy, 1'b1);
      end
      if (abort_at > 0 && n_en == abort_at) begin
        pReset = 1'b1;
        @(posedge prog_clk); #1;
        pReset = 1'b0;
        s_if.s_valid = 1'b0;
        check_eq({name, "_shift_en_after_rst"}, chain_shift_en, 1'b0);
        check_eq({name, "_busy_after_rst"}, busy, 1'b0);
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
          if (done) n_done++;
          @(posedge prog_clk); #1;
        end
        check_eq({name, "_no_done"}, n_done, 0);
        return;
      end
      if (done_rel >= 0 && rel > done_rel) break;
      @(posedge prog_clk); #1;
      rel++;
    end
    s_if.s_valid = 1'b0;

    check_eq({name, "_done_pulses"}, n_done, 1);
    check_eq({name, "_en_cycles"}, n_en, do_verify ? 2 * ChainLen : ChainLen);
    if (!stall) begin
      check_eq({name, "_first_en"}, first_en, 2);
      check_eq({name, "_last_en"}, last_en, exp_done - 1);
      check_eq({name, "_done_cycle"}, done_rel, exp_done);
    end
    check_eq({name, "_bytes_accepted"}, n_acc, 9);
    check_eq({name, "_crc_out"}, crc_out, crc_model(ExpChain));
    check_eq({name, "_crc_err"}, crc_err, exp_err);
    if (!tail_stuck) check_eq({name, "_chain"}, chain_q, ExpChain);
  endtask

  initial begin
    pReset = 1'b1; start = 1'b0; verify_en = 1'b0;
    s_if.s_valid = 1'b0; s_if.s_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge prog_clk); #1;
      start        = (i == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      verify_en    = 1'($urandom_range(0, 1));
      s_if.s_valid = 1'($urandom_range(0, 1));
      s_if.s_data  = 8'($urandom_range(0, 255));
    end
    check_eq("rst_s_ready", s_if.s_ready, 1'b0);
    check_eq("rst_ccff_head", ccff_head, 1'b0);
    check_eq("rst_shift_en", chain_shift_en, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_crc_err", crc_err, 1'b0);
    check_eq("rst_crc_out", crc_out, 16'hFFFF);
    // start was high together with pReset on the last edge: reset must win.
    @(posedge prog_clk); #1;
    pReset = 1'b0; start = 1'b0; s_if.s_valid = 1'b0;
    check_eq("rst_wins_busy", busy, 1'b0);
    @(posedge prog_clk); #1;
    check_eq("idle_busy", busy, 1'b0);

    run_load("cont",   1'b0, 1'b0, 0,  ChainLen + 2,     1'b0);
    run_load("stall",  1'b0, 1'b1, 0,  -1,               1'b0);
    run_load("verify", 1'b1, 1'b0, 0,  2 * ChainLen + 2, 1'b0);
    tail_stuck = 1'b1;
    run_load("fault",  1'b1, 1'b0, 0,  2 * ChainLen + 2, 1'b1);
    tail_stuck = 1'b0;
    run_load("abort",  1'b0, 1'b0, 30, ChainLen + 2,     1'b0);
    run_load("reload", 1'b0, 1'b0, 0,  ChainLen + 2,     1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
